// File: rtl/input_debounce_sync.sv
// Input synchronizer and debounce filter with edge-event handshake.
// Raw pin level is synchronized, filtered, and reported as level, pulses and a pending event.
module input_debounce_sync #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic d_async,
  input  logic ack,
  output logic q,
  output logic rise,
  output logic fall,
  output logic event_valid,
  output logic event_dir,
  output logic overrun
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LOW,
    CHECK_HIGH,
    STABLE_HIGH,
    CHECK_LOW
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   d_sync;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             q_q;
  logic             q_d;
  logic             rise_q;
  logic             rise_d;
  logic             fall_q;
  logic             fall_d;

  logic             ev_valid_q;
  logic             ev_valid_d;
  logic             ev_dir_q;
  logic             ev_dir_d;
  logic             ovr_q;
  logic             ovr_d;
  logic             ev_new;

  // Shift the raw level through the synchronizer every cycle.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_async};
  end

  assign d_sync = sync_q[SYNC_STAGES-1];

  // Debounce FSM: a new level must persist for the full count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (enable) begin
      unique case (state_q)
        STABLE_LOW: begin
          if (d_sync) begin
            state_d = CHECK_HIGH;
            cnt_d   = '0;
          end
        end
        CHECK_HIGH: begin
          if (!d_sync) begin
            state_d = STABLE_LOW;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = STABLE_HIGH;
            cnt_d   = '0;
            q_d     = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STABLE_HIGH: begin
          if (!d_sync) begin
            state_d = CHECK_LOW;
            cnt_d   = '0;
          end
        end
        CHECK_LOW: begin
          if (d_sync) begin
            state_d = STABLE_HIGH;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = STABLE_LOW;
            cnt_d   = '0;
            q_d     = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign ev_new = rise_d | fall_d;

  // Event handshake: a new edge wins over an ack in the same cycle.
  always_comb begin
    ev_valid_d = ev_valid_q;
    ev_dir_d   = ev_dir_q;
    ovr_d      = ovr_q;
    priority case (1'b1)
      ev_new: begin
        ev_valid_d = 1'b1;
        ev_dir_d   = rise_d;
        if (ev_valid_q && !ack) begin
          ovr_d = 1'b1;
        end
      end
      (ev_valid_q && ack): begin
        ev_valid_d = 1'b0;
      end
      default: begin
        ev_valid_d = ev_valid_q;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      state_q    <= STABLE_LOW;
      cnt_q      <= '0;
      q_q        <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      ev_valid_q <= 1'b0;
      ev_dir_q   <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      q_q        <= q_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      ev_valid_q <= ev_valid_d;
      ev_dir_q   <= ev_dir_d;
      ovr_q      <= ovr_d;
    end
  end

  assign q           = q_q;
  assign rise        = rise_q;
  assign fall        = fall_q;
  assign event_valid = ev_valid_q;
  assign event_dir   = ev_dir_q;
  assign overrun     = ovr_q;

endmodule
